// File: rtl/usr_cmd_sequencer_if.sv
// Command and shift-register control bundle for usr_cmd_sequencer.
// Handshake: a command transfers on a rising clk edge where cmd_valid && cmd_ready
// are both high. cmd_ready depends only on the sequencer state, never on cmd_valid.
// A sender holds cmd_valid and the fields stable until that edge.
interface usr_cmd_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [CNT_W-1:0] cmd_len;
    logic [1:0]       s;
    logic [WIDTH-1:0] din;
    logic             sin;
    logic             busy;
    logic             done;
    logic [1:0]       dbg_state;

    // Command source side; it also observes the register controls.
    modport master (
        output cmd_valid, cmd_op, cmd_data, cmd_len,
        input  cmd_ready, s, din, sin, busy, done, dbg_state
    );

    // Sequencer side.
    modport slave (
        input  cmd_valid, cmd_op, cmd_data, cmd_len,
        output cmd_ready, s, din, sin, busy, done, dbg_state
    );
endinterface

// File: rtl/usr_cmd_sequencer.sv
// Command front-end for a universal shift register. It accepts one command at a time
// and drives registered s/din/sin controls for the required number of cycles.
// After the last control cycle it raises done for one cycle.
module usr_cmd_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input logic                  clk,
    input logic                  rst,
    usr_cmd_sequencer_if.slave   bus
);
    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_SHR = 2'b01;
    localparam logic [1:0] OP_SHL = 2'b10;
    localparam logic [1:0] OP_LD  = 2'b11;

    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SHIFT = 2'd2, DONE = 2'd3} state_t;

    state_t           state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [WIDTH-1:0] bits_q, bits_n;
    logic [1:0]       s_q, s_n;
    logic [WIDTH-1:0] din_q, din_n;
    logic             sin_q, sin_n;
    logic             busy_q, busy_n;
    logic             done_q, done_n;

    logic             xfer;

    assign bus.cmd_ready = (state_q == IDLE);
    assign xfer          = bus.cmd_valid && (state_q == IDLE);

    assign bus.s         = s_q;
    assign bus.din       = din_q;
    assign bus.sin       = sin_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.dbg_state = state_q;

    // State and output registers; every output comes straight from a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bits_q  <= '0;
            s_q     <= OP_NOP;
            din_q   <= '0;
            sin_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            bits_q  <= bits_n;
            s_q     <= s_n;
            din_q   <= din_n;
            sin_q   <= sin_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
        end
    end

    // Next-state and next-output decode; busy/done follow the next state so they are registered.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        bits_n  = bits_q;
        s_n     = s_q;
        din_n   = din_q;
        sin_n   = sin_q;

        case (state_q)
            IDLE: begin
                s_n   = OP_NOP;
                sin_n = 1'b0;
                if (xfer) begin
                    if (bus.cmd_op == OP_LD) begin
                        state_n = LOAD;
                        din_n   = bus.cmd_data;
                        s_n     = OP_LD;
                    end else if ((bus.cmd_op == OP_SHR || bus.cmd_op == OP_SHL) &&
                                 (bus.cmd_len != '0)) begin
                        state_n = SHIFT;
                        s_n     = bus.cmd_op;
                        sin_n   = bus.cmd_data[0];
                        bits_n  = bus.cmd_data >> 1;
                        cnt_n   = bus.cmd_len;
                    end else begin
                        // No-op and zero-length shifts only produce the done pulse.
                        state_n = DONE;
                    end
                end
            end
            LOAD: begin
                state_n = DONE;
                s_n     = OP_NOP;
            end
            SHIFT: begin
                // cnt holds the shift cycles left including the current one.
                if (cnt_q == CNT_W'(1)) begin
                    state_n = DONE;
                    s_n     = OP_NOP;
                    sin_n   = 1'b0;
                    cnt_n   = '0;
                    bits_n  = '0;
                end else begin
                    cnt_n  = cnt_q - CNT_W'(1);
                    sin_n  = bits_q[0];
                    bits_n = bits_q >> 1;
                end
            end
            DONE: begin
                state_n = IDLE;
                s_n     = OP_NOP;
            end
            default: begin
                state_n = IDLE;
                s_n     = OP_NOP;
                sin_n   = 1'b0;
            end
        endcase

        busy_n = (state_n != IDLE);
        done_n = (state_n == DONE);
    end
endmodule

// File: tb/tb_usr_cmd_sequencer.sv
// Self-checking bench for usr_cmd_sequencer. A driver issues directed commands and
// queues the expected per-command summary when each one is accepted. A monitor
// tracks the control outputs between acceptance and done, together with a
// downstream shift-register model, then pops and compares.
module tb_usr_cmd_sequencer;
    localparam int WIDTH = 4;
    localparam int CNT_W = 3;
    localparam int EW    = 31;

    logic clk;
    logic rst;

    usr_cmd_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    usr_cmd_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [EW-1:0] exp_q[$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream universal shift register: 01 shifts right (sin into MSB),
    // 10 shifts left (sin into LSB), 11 loads din.
    logic [WIDTH-1:0] q;
    always @(posedge clk or posedge rst) begin
        if (rst) q <= '0;
        else begin
            case (bus.s)
                2'b01: q <= {bus.sin, q[WIDTH-1:1]};
                2'b10: q <= {q[WIDTH-2:0], bus.sin};
                2'b11: q <= bus.din;
                default: q <= q;
            endcase
        end
    end

    // Summary word: mode, active cycles, sin bits (first bit in bit 0), latency,
    // busy cycles, din at done, downstream q at done, ready-while-busy flag.
    function automatic logic [EW-1:0] pack(input logic [1:0] m, input logic [3:0] na,
                                           input logic [7:0] sb, input logic [3:0] lat,
                                           input logic [3:0] bc, input logic [3:0] d,
                                           input logic [3:0] qq, input logic v);
        return {m, na, sb, lat, bc, d, qq, v};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic       active = 1'b0;
    logic       chk_gap = 1'b0;
    logic [1:0] m_mode;
    logic [3:0] m_na, m_lat, m_bc;
    logic [7:0] m_sb;
    logic       m_v;
    int         m_sc;
    int         gap = 0;
    logic [EW-1:0] obs, expw;

    // Sample on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            active = 1'b0;
        end else begin
            gap++;
            if (active) begin
                m_lat++;
                if (bus.busy) m_bc++;
                if (bus.s != 2'b00) begin
                    m_na++;
                    m_mode = bus.s;
                end
                if ((bus.s == 2'b01 || bus.s == 2'b10) && m_sc < 8) begin
                    m_sb[m_sc] = bus.sin;
                    m_sc++;
                end
                if (bus.busy && bus.cmd_ready) m_v = 1'b1;
                if (bus.done) begin
                    obs = pack(m_mode, m_na, m_sb, m_lat, m_bc, bus.din, q, m_v);
                    n_tests++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL cmd_result: got %h, expected nothing queued", obs);
                    end else begin
                        expw = exp_q.pop_front();
                        if (obs !== expw) begin
                            n_fail++;
                            $display("FAIL cmd_result: got %h, expected %h", obs, expw);
                        end
                    end
                    active = 1'b0;
                    gap = 0;
                end
            end else if (bus.done) begin
                n_tests++;
                n_fail++;
                $display("FAIL stray_done: got done=1, expected 0");
            end
            if (bus.cmd_valid && bus.cmd_ready) begin
                if (chk_gap) check("idle_gap", 8'(gap), 8'd1);
                active = 1'b1;
                m_mode = 2'b00;
                m_na = '0; m_lat = '0; m_bc = '0; m_sb = '0; m_v = 1'b0; m_sc = 0;
            end
        end
    end

    // ---------------- driver ----------------
    // Presents a command and holds it until accepted; cmd_valid stays high afterwards.
    task automatic send(input logic [1:0] op, input logic [3:0] data, input logic [2:0] len,
                        input logic [EW-1:0] e);
        int w;
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        bus.cmd_len   = len;
        bus.cmd_valid = 1'b1;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!bus.cmd_ready && w < 50);
        if (!bus.cmd_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: got cmd_ready=0, expected 1 within 50 cycles");
        end else begin
            exp_q.push_back(e);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic release_cmd();
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_data  = '0;
        bus.cmd_len   = '0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || active) && w < 200) begin
            @(posedge clk);
            w++;
        end
        n_tests++;
        if (exp_q.size() != 0 || active) begin
            n_fail++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        release_cmd();
        repeat (2) @(posedge clk);
        #1;
        check("rst_s",     8'(bus.s),         8'd0);
        check("rst_din",   8'(bus.din),       8'd0);
        check("rst_sin",   8'(bus.sin),       8'd0);
        check("rst_busy",  8'(bus.busy),      8'd0);
        check("rst_done",  8'(bus.done),      8'd0);
        check("rst_ready", 8'(bus.cmd_ready), 8'd1);
        check("rst_state", 8'(bus.dbg_state), 8'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset in the middle of a shift right of length 5: no done, no queued result.
        bus.cmd_op = 2'b01; bus.cmd_data = 4'hD; bus.cmd_len = 3'd5; bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        release_cmd();
        repeat (2) @(posedge clk);
        #3;
        check("mid_s_before", 8'(bus.s), 8'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_s",     8'(bus.s),         8'd0);
        check("mid_rst_sin",   8'(bus.sin),       8'd0);
        check("mid_rst_busy",  8'(bus.busy),      8'd0);
        check("mid_rst_done",  8'(bus.done),      8'd0);
        check("mid_rst_ready", 8'(bus.cmd_ready), 8'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;

        // Load A: s=11 one cycle, done at k+2, q=A.
        send(2'b11, 4'hA, 3'd0, pack(2'b11, 4'd1, 8'h00, 4'd2, 4'd2, 4'hA, 4'hA, 1'b0));
        release_cmd();
        drain();

        // Shift right 1011 x4: sin 1,1,0,1; busy 5 cycles; q=1011.
        send(2'b01, 4'b1011, 3'd4, pack(2'b01, 4'd4, 8'h0B, 4'd5, 4'd5, 4'hA, 4'hB, 1'b0));
        release_cmd();
        drain();

        // Over-length shift left 0011 x7: sin 1,1,0,0,0,0,0; q ends 0000.
        send(2'b10, 4'b0011, 3'd7, pack(2'b10, 4'd7, 8'h03, 4'd8, 4'd8, 4'hA, 4'h0, 1'b0));
        release_cmd();
        drain();

        // Zero-length shift and no-op: done at k+1, s never leaves 00.
        send(2'b01, 4'hF, 3'd0, pack(2'b00, 4'd0, 8'h00, 4'd1, 4'd1, 4'hA, 4'h0, 1'b0));
        release_cmd();
        drain();
        send(2'b00, 4'h5, 3'd3, pack(2'b00, 4'd0, 8'h00, 4'd1, 4'd1, 4'hA, 4'h0, 1'b0));
        release_cmd();
        drain();

        // Three queued commands with cmd_valid held high throughout.
        send(2'b11, 4'h5, 3'd0, pack(2'b11, 4'd1, 8'h00, 4'd2, 4'd2, 4'h5, 4'h5, 1'b0));
        chk_gap = 1'b1;
        send(2'b01, 4'b0001, 3'd2, pack(2'b01, 4'd2, 8'h01, 4'd3, 4'd3, 4'h5, 4'h5, 1'b0));
        send(2'b10, 4'b0110, 3'd3, pack(2'b10, 4'd3, 8'h06, 4'd4, 4'd4, 4'h5, 4'hB, 1'b0));
        release_cmd();
        drain();
        chk_gap = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/usr_cmd_sequencer.md
Name: usr_cmd_sequencer

Overview:
- Command front-end that sits directly upstream of the 4-bit universal shift register and produces its mode-select, parallel-data and serial-in controls.
- Accepts one command at a time over a valid/ready handshake: parallel load, shift right N, shift left N, or no-op.
- Drives the register controls for the required number of cycles, then pulses done.
- All outputs are registered, so the register sees clean, glitch-free controls.

Parameters:
- WIDTH, 4, data width of the downstream shift register.
- CNT_W, 3, width of the shift-length field; maximum length is 2^CNT_W-1.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_op  input  2  operation code: 00 no-op, 01 shift right, 10 shift left, 11 load.
- cmd_data  input  WIDTH  for load, the parallel value; for shifts, the serial bit source, sent LSB first.
- cmd_len  input  CNT_W  number of shift cycles; ignored for load and no-op.
- s  output  2  mode select to the shift register; encoding identical to cmd_op, 00 means hold.
- din  output  WIDTH  parallel data to the shift register.
- sin  output  1  serial input bit to the shift register.
- busy  output  1  high while a command is executing, including the DONE cycle.
- done  output  1  one-cycle pulse when a command completes.

Behaviour:
- Reset is asynchronous and active-high (rst), clock is clk. While rst is high:
  - state=IDLE, s=00, din=0, sin=0, busy=0, done=0, cmd_ready=1.
  - Internal counter and bit buffer are cleared.
- Handshake:
  - A transfer occurs on a rising edge where cmd_valid && cmd_ready.
  - cmd_ready = (state==IDLE), combinational from state only; it does not depend on cmd_valid.
  - Command fields are captured at the transfer edge and may change afterwards.
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - s=00, sin=0, din holds its last value, busy=0.
  - On transfer, busy goes to 1 on the same edge, then:
    - op=11 -> LOAD; din<=cmd_data, s<=11.
    - op=01 or 10 with cmd_len!=0 -> SHIFT; s<=op, sin<=cmd_data[0], buf<=cmd_data>>1, cnt<=cmd_len.
    - op=00, or a shift with cmd_len==0 -> DONE directly; s stays 00.
- LOAD:
  - Lasts exactly one cycle with s=11; the register loads on the following edge.
  - Next state DONE; s<=00.
- SHIFT:
  - Each cycle s=op and sin=current buffer LSB.
  - On each edge: cnt<=cnt-1, sin<=buf[0], buf<=buf>>1, with zero filled into the MSB.
  - When cnt==1 on an edge -> DONE, s<=00, sin<=0.
  - s is therefore non-hold for exactly cmd_len consecutive cycles.
  - The serial bit sequence is cmd_data[0], cmd_data[1], ...; for cmd_len>WIDTH, bits beyond WIDTH are 0.
- DONE:
  - done=1 and busy=1 for one cycle; s=00.
  - Next state IDLE, where done=0 and busy=0.
- Latency: a command accepted at edge k drives s from cycle k+1.
  - Load: done is high during cycle k+2.
  - Shift of N: done is high during cycle k+N+1.
  - No-op: done is high during cycle k+1.
  - Next command can be accepted at the edge ending the DONE cycle+1, i.e. after returning to IDLE.
- Back-to-back: cmd_valid held high with new commands gives one command per (execution + DONE + IDLE) cycles; no command is ever dropped or duplicated.
- Boundaries:
  - cmd_valid while busy is not accepted; the sender must hold it until cmd_ready.
  - cnt arithmetic is unsigned CNT_W-bit; cmd_len=2^CNT_W-1 produces exactly that many shift cycles with no wrap.
  - Reset mid-command immediately returns all outputs to their reset values; no done pulse is produced for the aborted command.
- No other combinational paths from inputs to outputs.

Test Plan:
- Reset: assert rst mid-SHIFT (cmd op=01, len=5, after 2 shift cycles) -> s=00, sin=0, busy=0, done=0 immediately; no done pulse; cmd_ready=1.
- Load: op=11, data=4'hA accepted at edge k -> s=11 and din=A during cycle k+1; done during k+2; downstream register q=A afterwards.
- Shift right: op=01, data=4'b1011, len=4 -> s=01 for exactly 4 cycles; sin sequence 1,1,0,1; done one cycle later; busy high for 5 cycles.
- Over-length shift: op=10, data=4'b0011, len=7 -> sin sequence 1,1,0,0,0,0,0; s=10 for 7 cycles; then done.
- Zero cases: op=01 with len=0, and op=00 -> s never leaves 00; done pulses during cycle k+1.
- Handshake: cmd_valid held high for 3 queued commands while busy -> cmd_ready low throughout execution; each command executes exactly once, in order, with one idle cycle between done and the next acceptance.
